make_reset_seq: RTL and testbench

//  Multi-channel reset generator with sequenced release. It is the parametrised successor
//  of the single-channel make-reset primitive. Each of NCHAN active-low reset outputs is

---
 rtl/make_reset_seq_pkg.sv | 27 ++
 rtl/reset_hold_chan.sv | 65 ++++++
 rtl/make_reset_seq.sv | 78 +++++++
 tb/tb_make_reset_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/make_reset_seq_pkg.sv
// Shared helpers for the sequenced multi-channel reset generator.
// Width derivation lives here so the channel and arbiter agree on counter sizes.
package make_reset_seq_pkg;

  localparam int DEF_NCHAN      = 4;
  localparam int DEF_MIN_CYCLES = 16;
  localparam int DEF_STAGGER    = 4;
  localparam int DEF_RSTDELAY   = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Counters are sized [clog2(n):0], i.e. one bit wider than strictly needed.
  function automatic int cnt_width(input int max_count);
    return clog2(max_count) + 1;
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_MIN_CYCLES);
  localparam int DEF_GAP_W = cnt_width(DEF_STAGGER);

endpackage

// File: rtl/reset_hold_chan.sv
// One reset channel: request/hold counter, internal reset state and output delay pipe.
// Release is granted externally by the arbiter; the channel only reports readiness.
module reset_hold_chan
  import make_reset_seq_pkg::*;
#(
  parameter int MIN_CYCLES = DEF_MIN_CYCLES,
  parameter int RSTDELAY   = DEF_RSTDELAY,
  parameter bit INIT       = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic req,
  input  logic rel,
  output logic rst_i,
  output logic ready,
  output logic out_rst
);

  localparam int            CW       = cnt_width(MIN_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MIN_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      rst_i <= INIT;
      cnt   <= INIT ? '0 : CNT_LOAD;
    end else if (req) begin
      // A live request always wins over a pending release and restarts the hold.
      rst_i <= 1'b0;
      cnt   <= CNT_LOAD;
    end else begin
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (rel) begin
        rst_i <= 1'b1;
      end
    end
  end

  assign ready = !rst_i && (cnt == '0) && !req;

  generate
    if (RSTDELAY == 0) begin : g_no_pipe
      assign out_rst = rst_i;
    end else begin : g_pipe
      logic [RSTDELAY-1:0] pipe;

      always_ff @(posedge CLK) begin
        if (!RST) begin
          pipe <= {RSTDELAY{INIT}};
        end else begin
          pipe[0] <= rst_i;
          for (int s = 1; s < RSTDELAY; s++) begin
            pipe[s] <= pipe[s-1];
          end
        end
      end

      assign out_rst = pipe[RSTDELAY-1];
    end
  endgenerate

endmodule

// File: rtl/make_reset_seq.sv
// Multi-channel reset generator: per-channel holds, released in ascending order
// with a minimum stagger gap between consecutive releases.
module make_reset_seq
  import make_reset_seq_pkg::*;
#(
  parameter int NCHAN      = DEF_NCHAN,
  parameter int MIN_CYCLES = DEF_MIN_CYCLES,
  parameter int STAGGER    = DEF_STAGGER,
  parameter int RSTDELAY   = DEF_RSTDELAY,
  parameter bit INIT       = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NCHAN-1:0] ASSERT_IN,
  input  logic             ASSERT_ALL,
  output logic [NCHAN-1:0] ASSERT_OUT,
  output logic [NCHAN-1:0] OUT_RST,
  output logic             BUSY
);

  localparam int            GW       = cnt_width(STAGGER);
  localparam logic [GW-1:0] GAP_LOAD = GW'(STAGGER - 1);

  logic [NCHAN-1:0] req;
  logic [NCHAN-1:0] rst_q;
  logic [NCHAN-1:0] ready;
  logic [NCHAN-1:0] rel;
  logic [GW-1:0]    gap;
  logic             blocked;

  assign req = ASSERT_IN | {NCHAN{ASSERT_ALL}};

  // Only the lowest still-asserted channel can be granted, so at most one release per edge.
  always_comb begin
    rel     = '0;
    blocked = 1'b0;
    for (int i = 0; i < NCHAN; i++) begin
      if (!blocked && ready[i] && (gap == '0)) begin
        rel[i] = 1'b1;
      end
      if (!rst_q[i]) begin
        blocked = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      gap <= '0;
    end else if (|rel) begin
      gap <= GAP_LOAD;
    end else if (gap != '0) begin
      gap <= gap - 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
      reset_hold_chan #(
        .MIN_CYCLES (MIN_CYCLES),
        .RSTDELAY   (RSTDELAY),
        .INIT       (INIT)
      ) u_chan (
        .CLK     (CLK),
        .RST     (RST),
        .req     (req[gi]),
        .rel     (rel[gi]),
        .rst_i   (rst_q[gi]),
        .ready   (ready[gi]),
        .out_rst (OUT_RST[gi])
      );
    end
  endgenerate

  assign ASSERT_OUT = ~rst_q;
  assign BUSY       = (|ASSERT_OUT) || (gap != '0);

endmodule

// File: tb/tb_make_reset_seq.sv
// Scoreboard bench for make_reset_seq: stimulus queues expected release edges,
// a negedge monitor pops them as releases and OUT_RST rises appear.
module tb_make_reset_seq;

  localparam int RD = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] ASSERT_IN = '0;
  logic       ASSERT_ALL = 1'b0;
  logic [3:0] ASSERT_OUT, OUT_RST;
  logic       BUSY;

  logic [3:0] ASSERT_IN0 = '0;
  logic       ASSERT_ALL0 = 1'b0;
  logic [3:0] ASSERT_OUT0, OUT_RST0;
  logic       BUSY0;

  always #5 CLK = ~CLK;

  make_reset_seq #(
    .NCHAN(4), .MIN_CYCLES(16), .STAGGER(4), .RSTDELAY(RD), .INIT(1'b1)
  ) dut (
    .CLK(CLK), .RST(RST), .ASSERT_IN(ASSERT_IN), .ASSERT_ALL(ASSERT_ALL),
    .ASSERT_OUT(ASSERT_OUT), .OUT_RST(OUT_RST), .BUSY(BUSY)
  );

  make_reset_seq #(
    .NCHAN(4), .MIN_CYCLES(16), .STAGGER(4), .RSTDELAY(RD), .INIT(1'b0)
  ) dut0 (
    .CLK(CLK), .RST(RST), .ASSERT_IN(ASSERT_IN0), .ASSERT_ALL(ASSERT_ALL0),
    .ASSERT_OUT(ASSERT_OUT0), .OUT_RST(OUT_RST0), .BUSY(BUSY0)
  );

  typedef struct {
    int ch;
    int edge_n;
  } ev_t;

  ev_t  rel_q[$];
  ev_t  out_q[$];
  int   checks = 0;
  int   failures = 0;
  int   ecnt = 0;
  logic rst_smp = 1'b0;
  logic [3:0] prev_ao = '0;
  logic [3:0] prev_or = '1;

  always @(posedge CLK) begin
    ecnt    <= ecnt + 1;
    rst_smp <= RST;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  task automatic score(input bit is_out, input int ch);
    ev_t   e;
    string nm;
    int    sz;
    nm = is_out ? "out_rst_rise" : "release";
    sz = is_out ? out_q.size() : rel_q.size();
    checks++;
    if (sz == 0) begin
      failures++;
      $display("FAIL %s: got ch%0d at edge %0d, required no event", nm, ch, ecnt);
      return;
    end
    if (is_out) e = out_q.pop_front();
    else        e = rel_q.pop_front();
    if (e.ch != ch || e.edge_n != ecnt) begin
      failures++;
      $display("FAIL %s: got ch%0d edge %0d, required ch%0d edge %0d",
               nm, ch, ecnt, e.ch, e.edge_n);
    end
  endtask

  // Events caused by RST itself are not releases and are skipped.
  always @(negedge CLK) begin
    if (rst_smp) begin
      for (int i = 0; i < 4; i++) begin
        if (prev_ao[i] === 1'b1 && ASSERT_OUT[i] === 1'b0) score(1'b0, i);
        if (prev_or[i] === 1'b0 && OUT_RST[i] === 1'b1)    score(1'b1, i);
      end
    end
    prev_ao = ASSERT_OUT;
    prev_or = OUT_RST;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_to(input int e);
    while (ecnt < e) tick();
  endtask

  task automatic pulse(input logic [3:0] in, input logic all);
    ASSERT_IN  = in;
    ASSERT_ALL = all;
    tick();
    ASSERT_IN  = '0;
    ASSERT_ALL = 1'b0;
  endtask

  task automatic expect_rel(input int ch, input int e);
    rel_q.push_back('{ch: ch, edge_n: e});
    out_q.push_back('{ch: ch, edge_n: e + RD});
  endtask

  initial begin
    int base;
    int k;

    // Reset state, both INIT flavours
    RST = 1'b0;
    repeat (3) tick();
    check("rst_out_rst_init1", OUT_RST, 4'b1111);
    check("rst_assert_out_init1", ASSERT_OUT, 4'b0000);
    check("rst_busy_init1", BUSY, 1'b0);
    check("rst_out_rst_init0", OUT_RST0, 4'b0000);
    check("rst_assert_out_init0", ASSERT_OUT0, 4'b1111);
    check("rst_busy_init0", BUSY0, 1'b1);

    // INIT=0 sequenced release at 16/20/24/28
    RST  = 1'b1;
    base = ecnt;
    run_to(base + 15); check("init0_e15", ASSERT_OUT0, 4'b1111);
    run_to(base + 16); check("init0_e16", ASSERT_OUT0, 4'b1110);
    run_to(base + 18); check("init0_out_e18", OUT_RST0, 4'b0001);
    run_to(base + 19); check("init0_e19", ASSERT_OUT0, 4'b1110);
    run_to(base + 20); check("init0_e20", ASSERT_OUT0, 4'b1100);
    run_to(base + 24); check("init0_e24", ASSERT_OUT0, 4'b1000);
    run_to(base + 28); check("init0_e28", ASSERT_OUT0, 4'b0000);
    run_to(base + 30); check("init0_busy_e30", BUSY0, 1'b1);
    check("init0_out_e30", OUT_RST0, 4'b1111);
    run_to(base + 31); check("init0_busy_e31", BUSY0, 1'b0);
    check("init1_idle", ASSERT_OUT, 4'b0000);

    // Single-channel pulse on ch2
    k = ecnt + 1;
    expect_rel(2, k + 16);
    pulse(4'b0100, 1'b0);
    check("ch2_assert_k", ASSERT_OUT, 4'b0100);
    check("ch2_out_k", OUT_RST, 4'b1111);
    run_to(k + 2);  check("ch2_out_k2", OUT_RST, 4'b1011);
    run_to(k + 15); check("ch2_assert_k15", ASSERT_OUT, 4'b0100);
    run_to(k + 17); check("ch2_out_k17", OUT_RST, 4'b1011);
    run_to(k + 18); check("ch2_out_k18", OUT_RST, 4'b1111);
    check("ch2_busy_k18", BUSY, 1'b1);
    run_to(k + 19); check("ch2_busy_k19", BUSY, 1'b0);

    // ASSERT_ALL: staggered release of all channels
    repeat (3) tick();
    k = ecnt + 1;
    expect_rel(0, k + 16); expect_rel(1, k + 20);
    expect_rel(2, k + 24); expect_rel(3, k + 28);
    pulse(4'b0000, 1'b1);
    check("all_assert_k", ASSERT_OUT, 4'b1111);
    run_to(k + 2);  check("all_out_k2", OUT_RST, 4'b0000);
    run_to(k + 30); check("all_busy_k30", BUSY, 1'b1);
    run_to(k + 31); check("all_busy_k31", BUSY, 1'b0);
    check("all_out_k31", OUT_RST, 4'b1111);

    // Low-index priority: ch3 expires early but waits for ch0
    repeat (2) tick();
    k = ecnt + 1;
    expect_rel(0, k + 55);
    expect_rel(3, k + 59);
    ASSERT_IN = 4'b1001;
    tick();
    ASSERT_IN = 4'b0001;
    repeat (39) tick();
    ASSERT_IN = 4'b0000;
    run_to(k + 54); check("prio_k54", ASSERT_OUT, 4'b1001);
    run_to(k + 58); check("prio_k58", ASSERT_OUT, 4'b1000);
    run_to(k + 62); check("prio_busy_k62", BUSY, 1'b0);

    // Re-request while holding restarts the full hold
    repeat (2) tick();
    k = ecnt + 1;
    expect_rel(1, k + 24);
    pulse(4'b0010, 1'b0);
    run_to(k + 7);
    pulse(4'b0010, 1'b0);
    run_to(k + 23); check("rereq_k23", ASSERT_OUT, 4'b0010);
    run_to(k + 30);

    // Request on the edge the channel would have released
    k = ecnt + 1;
    expect_rel(2, k + 32);
    pulse(4'b0100, 1'b0);
    run_to(k + 15);
    pulse(4'b0100, 1'b0);
    check("collide_k16", ASSERT_OUT, 4'b0100);
    run_to(k + 36);

    // Reset mid-sequence aborts everything
    repeat (2) tick();
    k = ecnt + 1;
    expect_rel(0, k + 16);
    pulse(4'b0000, 1'b1);
    run_to(k + 19); check("abort_k19", ASSERT_OUT, 4'b1110);
    RST = 1'b0;
    tick();
    RST = 1'b1;
    check("abort_assert", ASSERT_OUT, 4'b0000);
    check("abort_out", OUT_RST, 4'b1111);
    check("abort_busy", BUSY, 1'b0);
    repeat (40) tick();
    check("abort_assert_late", ASSERT_OUT, 4'b0000);
    check("abort_out_late", OUT_RST, 4'b1111);
    check("abort_busy_late", BUSY, 1'b0);

    repeat (2) tick();
    check("release_queue_drained", rel_q.size(), 0);
    check("out_queue_drained", out_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
